control_pulse_sequencer: RTL and testbench

//  Downstream consumer of the seven-phase timing generator (tp1..tp7, one pulse per clk).

---
 rtl/control_pulse_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_control_pulse_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pulse_sequencer.sv
// Instruction sequencer driven by a seven-phase timing frame (tp1..tp7): runs each accepted
// instruction as one or two memory cycles, emits registered datapath strobes and checks frame integrity.
module control_pulse_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tp1,
  input  logic               tp2,
  input  logic               tp3,
  input  logic               tp4,
  input  logic               tp5,
  input  logic               tp6,
  input  logic               tp7,
  input  logic               req,
  input  logic [2:0]         opcode,
  output logic               ack,
  output logic               busy,
  output logic               done,
  output logic               op_err,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               a_to_g,
  output logic               g_to_a,
  output logic               adder_en,
  output logic               z_load,
  output logic               pc_inc,
  output logic               frame_err,
  output logic [COUNT_W-1:0] mct_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_MCT1,
    S_MCT2,
    S_ERROR
  } state_t;

  // Strobe vector bit positions
  localparam int SB_RD = 5;
  localparam int SB_WR = 4;
  localparam int SB_AG = 3;
  localparam int SB_GA = 2;
  localparam int SB_AD = 1;
  localparam int SB_ZL = 0;

  state_t               state_reg, state_next;
  logic [6:0]           phase_reg, phase_next;   // one-hot: phase expected on the next sample
  logic [2:0]           op_reg, op_next;
  logic                 run_reg;
  logic [5:0]           strobe_reg, strobe_next, strobe_sel;
  logic                 done_reg, done_next;
  logic                 op_err_reg, op_err_next;
  logic                 pc_inc_reg, pc_inc_next;
  logic                 frame_err_reg, frame_err_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic [6:0]           tp_vec;
  logic                 two_mct;
  logic                 illegal_op;

  assign tp_vec     = {tp7, tp6, tp5, tp4, tp3, tp2, tp1};
  assign two_mct    = (op_reg == 3'd3) || (op_reg == 3'd4);
  assign illegal_op = (op_reg >= 3'd5);

  // Strobes owed for the phase currently expected, given opcode and which MCT is running
  always_comb begin
    strobe_sel = '0;
    unique case (op_reg)
      3'd0: strobe_sel[SB_ZL] = phase_reg[2];
      3'd1: begin
        strobe_sel[SB_RD] = phase_reg[1];
        strobe_sel[SB_GA] = phase_reg[4];
      end
      3'd2: begin
        strobe_sel[SB_AG] = phase_reg[1];
        strobe_sel[SB_WR] = phase_reg[3];
      end
      3'd3, 3'd4: begin
        if (state_reg == S_MCT2) begin
          strobe_sel[SB_AG] = phase_reg[1];
          strobe_sel[SB_WR] = phase_reg[3];
        end else begin
          strobe_sel[SB_RD] = phase_reg[1];
          if (op_reg == 3'd3) strobe_sel[SB_AD] = phase_reg[4];
          else                strobe_sel[SB_GA] = phase_reg[5];
        end
      end
      default: strobe_sel = '0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    op_next        = op_reg;
    strobe_next    = '0;
    done_next      = 1'b0;
    op_err_next    = 1'b0;
    pc_inc_next    = 1'b0;
    frame_err_next = frame_err_reg;
    count_next     = count_reg;
    ack            = 1'b0;
    busy           = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (run_reg && req) begin
          ack        = 1'b1;
          busy       = 1'b1;
          op_next    = opcode;
          state_next = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        busy = 1'b1;
        if (tp_vec[0]) begin
          phase_next = 7'b0000010;
          state_next = S_MCT1;
        end
      end
      S_MCT1, S_MCT2: begin
        busy = 1'b1;
        // Exact match against the one-hot expectation also rejects multi-hot and empty samples
        if (tp_vec != phase_reg) begin
          frame_err_next = 1'b1;
          state_next     = S_ERROR;
        end else begin
          strobe_next = strobe_sel;
          phase_next  = {phase_reg[5:0], phase_reg[6]};
          if (phase_reg[6]) begin
            count_next = count_reg + COUNT_W'(1);
            if (state_reg == S_MCT1 && two_mct) begin
              state_next = S_MCT2;
            end else begin
              state_next  = S_IDLE;
              done_next   = 1'b1;
              op_err_next = illegal_op;
              pc_inc_next = (op_reg != 3'd0);
            end
          end
        end
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  // run_reg keeps ack low while reset is asserted and for the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      phase_reg     <= '0;
      op_reg        <= '0;
      run_reg       <= 1'b0;
      strobe_reg    <= '0;
      done_reg      <= 1'b0;
      op_err_reg    <= 1'b0;
      pc_inc_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      op_reg        <= op_next;
      run_reg       <= 1'b1;
      strobe_reg    <= strobe_next;
      done_reg      <= done_next;
      op_err_reg    <= op_err_next;
      pc_inc_reg    <= pc_inc_next;
      frame_err_reg <= frame_err_next;
      count_reg     <= count_next;
    end
  end

  assign mem_rd    = strobe_reg[SB_RD];
  assign mem_wr    = strobe_reg[SB_WR];
  assign a_to_g    = strobe_reg[SB_AG];
  assign g_to_a    = strobe_reg[SB_GA];
  assign adder_en  = strobe_reg[SB_AD];
  assign z_load    = strobe_reg[SB_ZL];
  assign done      = done_reg;
  assign op_err    = op_err_reg;
  assign pc_inc    = pc_inc_reg;
  assign frame_err = frame_err_reg;
  assign mct_count = count_reg;

endmodule

// File: tb/tb_control_pulse_sequencer.sv
// Randomized bench for control_pulse_sequencer: a frame-schedule model projects every expected
// output cycle by cycle at ack time, and each cycle's outputs are compared against that projection.
module tb_control_pulse_sequencer;

  localparam int CW   = 2;
  localparam int MAXC = 2048;
  localparam int INF  = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tp1, tp2, tp3, tp4, tp5, tp6, tp7;
  logic [6:0]    tp_drv;
  logic          req;
  logic [2:0]    opcode;
  logic          ack, busy, done, op_err, mem_rd, mem_wr, a_to_g, g_to_a, adder_en, z_load;
  logic          pc_inc, frame_err;
  logic [CW-1:0] mct_count;

  assign {tp7, tp6, tp5, tp4, tp3, tp2, tp1} = tp_drv;

  control_pulse_sequencer #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tp1(tp1), .tp2(tp2), .tp3(tp3), .tp4(tp4), .tp5(tp5), .tp6(tp6), .tp7(tp7),
    .req(req), .opcode(opcode), .ack(ack), .busy(busy), .done(done), .op_err(op_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .a_to_g(a_to_g), .g_to_a(g_to_a),
    .adder_en(adder_en), .z_load(z_load), .pc_inc(pc_inc), .frame_err(frame_err),
    .mct_count(mct_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Timing schedule and projected expectations, indexed by cycle
  logic [6:0] tpv    [MAXC];
  logic [5:0] e_strb [MAXC];   // {mem_rd, mem_wr, a_to_g, g_to_a, adder_en, z_load}
  bit         e_busy [MAXC];
  bit         e_done [MAXC];
  bit         e_operr[MAXC];
  bit         e_pcinc[MAXC];
  int         e_inc  [MAXC];
  int         free_c   = 0;
  int         err_from = INF;
  int         cnt_m    = 0;
  int         last_t1  = -1;
  bit         inject   = 1'b0;
  bit         rst_d    = 1'b0;
  bit         force_req = 1'b0;

  typedef struct { int op; int gap; } op_t;
  op_t q[$];
  int  cur_gap = 0;

  // Opcode table: strobes owed for phase ph (1..7) of memory cycle mct (0/1)
  function automatic logic [5:0] spec_strobes(input int op, input int mct, input int ph);
    logic [5:0] r;
    r = 6'b0;
    case (op)
      0: if (ph == 3) r = 6'b000001;
      1: if (ph == 2) r = 6'b100000; else if (ph == 5) r = 6'b000100;
      2: if (ph == 2) r = 6'b001000; else if (ph == 4) r = 6'b010000;
      3, 4: begin
        if (mct == 1) begin
          if (ph == 2) r = 6'b001000; else if (ph == 4) r = 6'b010000;
        end else if (ph == 2) r = 6'b100000;
        else if (op == 3 && ph == 5) r = 6'b000010;
        else if (op == 4 && ph == 6) r = 6'b000100;
      end
      default: r = 6'b0;
    endcase
    return r;
  endfunction

  task automatic project(input int a, input int op);
    int n;
    int t1;
    int t;
    logic [6:0] want;
    n  = (op == 3 || op == 4) ? 2 : 1;
    t1 = a + 1;
    while (!tpv[t1][0] && t1 < a + 20) t1++;
    last_t1 = t1;
    if (inject) begin
      tpv[t1 + 3] = 7'b0000100;
      inject = 1'b0;
    end
    for (int i = a; i <= t1; i++) e_busy[i] = 1'b1;
    for (int m = 0; m < n; m++) begin
      for (int k = 0; k < 7; k++) begin
        t = t1 + 7 * m + k;
        want = 7'd1 << k;
        e_busy[t] = 1'b1;
        if (!(m == 0 && k == 0) && tpv[t] != want) begin
          err_from = t + 1;
          free_c   = INF;
          return;
        end
        e_strb[t + 1] = e_strb[t + 1] | spec_strobes(op, m, k + 1);
        if (k == 6) e_inc[t + 1]++;
      end
    end
    e_done[t1 + 7 * n]  = 1'b1;
    e_pcinc[t1 + 7 * n] = (op != 0);
    e_operr[t1 + 7 * n] = (op >= 5);
    free_c = t1 + 7 * n;
  endtask

  task automatic push_op(input int op, input int gap);
    op_t e;
    e.op  = op;
    e.gap = gap;
    if (q.size() == 0) cur_gap = gap;
    q.push_back(e);
  endtask

  task automatic step();
    bit ack_e;
    @(posedge clk);
    #1;
    rst_n  = rst_d;
    tp_drv = tpv[cyc];
    req    = 1'b0;
    opcode = 3'($urandom_range(0, 7));
    if (rst_d && q.size() > 0) begin
      if (cur_gap > 0) cur_gap--;
      else begin
        req    = 1'b1;
        opcode = 3'(q[0].op);
      end
    end
    if (force_req) req = 1'b1;
    ack_e = 1'b0;
    if (!rst_d) begin
      for (int t = cyc; t < MAXC; t++) begin
        e_strb[t] = '0; e_busy[t] = 0; e_done[t] = 0; e_operr[t] = 0; e_pcinc[t] = 0; e_inc[t] = 0;
      end
      free_c   = cyc + 2;
      err_from = INF;
      cnt_m    = 0;
    end else begin
      ack_e = req && (cyc >= free_c);
      if (ack_e) begin
        project(cyc, int'(opcode));
        if (q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() > 0) cur_gap = q[0].gap;
        end
      end
      cnt_m = (cnt_m + e_inc[cyc]) % (1 << CW);
    end
    @(negedge clk);
    check_val("ack", 32'(ack), 32'(ack_e));
    check_val("busy", 32'(busy), 32'(e_busy[cyc]));
    check_val("done", 32'(done), 32'(e_done[cyc]));
    check_val("op_err", 32'(op_err), 32'(e_operr[cyc]));
    check_val("pc_inc", 32'(pc_inc), 32'(e_pcinc[cyc]));
    check_val("strobes", 32'({mem_rd, mem_wr, a_to_g, g_to_a, adder_en, z_load}), 32'(e_strb[cyc]));
    check_val("frame_err", 32'(frame_err), 32'(cyc >= err_from));
    check_val("mct_count", 32'(mct_count), 32'(cnt_m));
    cyc++;
    if (cyc >= MAXC - 40) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 40);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() > 0 || cyc < free_c) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_val("idle_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int off;
    int n;
    off = $urandom_range(0, 6);
    for (int i = 0; i < MAXC; i++) begin
      tpv[i] = 7'd1 << ((i + off) % 7);
      e_strb[i] = '0;
    end
    rst_n = 1'b0; req = 1'b0; opcode = '0; tp_drv = '0;

    // reset held with req high: everything must stay quiet
    force_req = 1'b1;
    repeat (4) step();
    force_req = 1'b0;
    rst_d = 1'b1;

    // directed ops, then back-to-back TS and chained ops with req held through done
    push_op(1, 3); push_op(3, 2); push_op(6, 1); push_op(2, 4);
    push_op(2, 0); push_op(4, 0); push_op(0, 0);
    run_idle(400);

    repeat (20) push_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 10)));
    run_idle(1200);

    // reset in the middle of an XCH second memory cycle
    last_t1 = -1;
    push_op(4, 1);
    n = 0;
    while (!(last_t1 >= 0 && cyc == last_t1 + 10) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_val("xch_timeout", 32'(n), 32'(0));
    rst_d = 1'b0;
    repeat (2) step();
    rst_d = 1'b1;
    push_op(2, 2); push_op(1, 0); push_op(3, 0);
    run_idle(200);

    // tp3 where tp4 is expected during MCT1 of a TS
    inject = 1'b1;
    push_op(2, 1);
    n = 0;
    while (!(cyc > err_from + 1) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_val("err_timeout", 32'(n), 32'(0));
    force_req = 1'b1;
    repeat (40) step();

    // only a reset pulse brings it back
    rst_d = 1'b0;
    step();
    rst_d = 1'b1;
    repeat (30) step();
    force_req = 1'b0;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
